// File: rtl/game_pkg.sv
// Shared definitions for the game-round controller: FSM encoding and default sizes.
package game_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StArm      = 3'd1,
        StRun      = 3'd2,
        StPause    = 3'd3,
        StRoundEnd = 3'd4,
        StOver     = 3'd5
    } state_e;

    localparam int unsigned DefNumRounds = 5;
    localparam int unsigned DefRoundW    = 3;
    localparam int unsigned DefTimerW    = 12;
    localparam int unsigned DefScoreW    = 16;
    localparam int unsigned DefArmCycles = 2;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector producing a registered one-cycle pulse per press.
module edge_detect #(
    parameter bit RESET_PREV = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;
    logic r_pulse;

    // Previous sample resets high so a button held through reset never fires.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev  <= RESET_PREV;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= i_level;
            r_pulse <= i_level & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/round_sequencer.sv
// Game-round controller: arms, runs, pauses and stops the countdown timer over a
// fixed number of rounds and accumulates a saturating score from hit times.
module round_sequencer
    import game_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = DefNumRounds,
    parameter int unsigned ROUND_W    = DefRoundW,
    parameter int unsigned TIMER_W    = DefTimerW,
    parameter int unsigned SCORE_W    = DefScoreW,
    parameter int unsigned ARM_CYCLES = DefArmCycles
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               hit_btn,
    input  logic               end_reached,
    input  logic [TIMER_W-1:0] timer_value,
    output logic               timer_reset,
    output logic               timer_enable,
    output logic [ROUND_W-1:0] round,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         state,
    output logic               round_done,
    output logic               game_over
);

    localparam int unsigned ArmW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

    state_e             r_state;
    state_e             w_state_next;
    logic [ArmW-1:0]    r_arm_cnt;
    logic [ROUND_W-1:0] r_round;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W:0]   w_sum;
    logic               w_start;
    logic               w_pause;
    logic               w_hit;
    logic               w_arm_done;
    logic               w_last_round;
    logic               w_new_game;

    edge_detect #(.RESET_PREV(1'b1)) u_start_edge (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_level (start_btn),
        .o_pulse (w_start)
    );

    edge_detect #(.RESET_PREV(1'b1)) u_pause_edge (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_level (pause_btn),
        .o_pulse (w_pause)
    );

    edge_detect #(.RESET_PREV(1'b1)) u_hit_edge (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_level (hit_btn),
        .o_pulse (w_hit)
    );

    assign w_arm_done   = (r_arm_cnt == ArmW'(ARM_CYCLES - 1));
    assign w_last_round = (r_round == ROUND_W'(NUM_ROUNDS));
    assign w_new_game   = w_start && (r_state == StIdle || r_state == StOver);
    assign w_sum        = {1'b0, r_score} + {{(SCORE_W + 1 - TIMER_W){1'b0}}, timer_value};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:     if (w_start) w_state_next = StArm;
            StArm:      if (w_arm_done) w_state_next = StRun;
            StRun: begin
                // hit outranks end_reached, which outranks pause
                if (w_hit || end_reached) begin
                    w_state_next = StRoundEnd;
                end else if (w_pause) begin
                    w_state_next = StPause;
                end
            end
            StPause:    if (w_pause) w_state_next = StRun;
            StRoundEnd: w_state_next = w_last_round ? StOver : StArm;
            StOver:     if (w_start) w_state_next = StArm;
            default:    w_state_next = StIdle;
        endcase
    end

    always_comb begin
        timer_reset  = 1'b0;
        timer_enable = 1'b0;
        round_done   = 1'b0;
        game_over    = 1'b0;
        case (r_state)
            StArm:      timer_reset  = 1'b1;
            StRun:      timer_enable = 1'b1;
            StRoundEnd: round_done   = 1'b1;
            StOver:     game_over    = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_arm_cnt <= '0;
        end else if (r_state == StArm && !w_arm_done) begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
        end else begin
            r_arm_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_round <= '0;
            r_score <= '0;
        end else if (w_new_game) begin
            r_round <= ROUND_W'(1);
            r_score <= '0;
        end else begin
            if (r_state == StRun && w_hit) begin
                r_score <= w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
            end
            if (r_state == StRoundEnd && !w_last_round) begin
                r_round <= r_round + 1'b1;
            end
        end
    end

    assign round = r_round;
    assign score = r_score;
    assign state = r_state;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: a cycle-by-cycle vector table for a full game,
// plus hand sequences for pause hold, async reset, held-start and score saturation.
module tb_round_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_btn, pause_btn, hit_btn, end_reached;
    logic [11:0] timer_value;
    logic        timer_reset, timer_enable, round_done, game_over;
    logic [2:0]  round;
    logic [15:0] score;
    logic [2:0]  state;

    logic        s_start, s_pause, s_hit, s_end;
    logic [11:0] s_tv;
    logic        s_tr, s_te, s_rd, s_go;
    logic [2:0]  s_round;
    logic [12:0] s_score;
    logic [2:0]  s_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    round_sequencer u_dut (
        .clk          (clk),
        .reset        (rst_n),
        .start_btn    (start_btn),
        .pause_btn    (pause_btn),
        .hit_btn      (hit_btn),
        .end_reached  (end_reached),
        .timer_value  (timer_value),
        .timer_reset  (timer_reset),
        .timer_enable (timer_enable),
        .round        (round),
        .score        (score),
        .state        (state),
        .round_done   (round_done),
        .game_over    (game_over)
    );

    // Narrow score so saturation is reachable within one game.
    round_sequencer #(.SCORE_W(13)) u_sat (
        .clk          (clk),
        .reset        (rst_n),
        .start_btn    (s_start),
        .pause_btn    (s_pause),
        .hit_btn      (s_hit),
        .end_reached  (s_end),
        .timer_value  (s_tv),
        .timer_reset  (s_tr),
        .timer_enable (s_te),
        .round        (s_round),
        .score        (s_score),
        .state        (s_state),
        .round_done   (s_rd),
        .game_over    (s_go)
    );

    typedef struct {
        logic        s, p, h, e;
        logic [11:0] tv;
        logic [2:0]  st;
        logic [2:0]  rnd;
        logic [15:0] sc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic p, input logic h, input logic e,
                                input logic [11:0] tv, input logic [2:0] st,
                                input logic [2:0] rnd, input logic [15:0] sc);
        vec_t v;
        v.s = s; v.p = p; v.h = h; v.e = e; v.tv = tv;
        v.st = st; v.rnd = rnd; v.sc = sc;
        return v;
    endfunction

    // Expected packed outputs: {state, timer_reset, timer_enable, round, score, done, over}
    function automatic logic [25:0] exp_outs(input logic [2:0] st, input logic [2:0] rnd,
                                             input logic [15:0] sc);
        return {st, st == 3'd1, st == 3'd2, rnd, sc, st == 3'd4, st == 3'd5};
    endfunction

    function automatic logic [25:0] act_outs();
        return {state, timer_reset, timer_enable, round, score, round_done, game_over};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic p, input logic h, input logic e,
                         input logic [11:0] tv);
        start_btn = s; pause_btn = p; hit_btn = h; end_reached = e; timer_value = tv;
    endtask

    task automatic sat_round(input logic [11:0] tv, input logic [12:0] exp, input string name);
        int n = 0;
        while (s_state !== 3'd2 && n < 10) begin
            tick();
            n++;
        end
        if (s_state !== 3'd2) begin
            chk({name, "_wait_run"}, {29'd0, s_state}, 32'd2);
        end else begin
            s_hit = 1'b1; s_tv = tv;
            tick();
            s_hit = 1'b0;
            tick();
            chk(name, {16'd0, s_state, s_score}, {16'd0, 3'd4, exp});
        end
    endtask

    localparam logic [2:0] I = 3'd0, A = 3'd1, R = 3'd2, P = 3'd3, E = 3'd4, O = 3'd5;

    initial begin
        int bad;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        s_start = 1'b0; s_pause = 1'b0; s_hit = 1'b0; s_end = 1'b0; s_tv = '0;

        // Full game, one row per clock: inputs applied, one edge, outputs compared.
        vecs.push_back(mk(0, 0, 0, 0, 0,    I, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,    I, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,    A, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,    A, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,    R, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1234, R, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1234, E, 1, 1234));
        vecs.push_back(mk(0, 0, 0, 0, 0,    A, 2, 1234));
        vecs.push_back(mk(0, 0, 0, 0, 0,    A, 2, 1234));
        vecs.push_back(mk(0, 0, 0, 0, 0,    R, 2, 1234));
        vecs.push_back(mk(0, 0, 0, 1, 0,    E, 2, 1234));
        vecs.push_back(mk(0, 0, 0, 0, 0,    A, 3, 1234));
        vecs.push_back(mk(0, 0, 0, 0, 0,    A, 3, 1234));
        vecs.push_back(mk(0, 0, 0, 0, 0,    R, 3, 1234));
        vecs.push_back(mk(0, 1, 0, 0, 0,    R, 3, 1234));
        vecs.push_back(mk(0, 0, 0, 0, 0,    P, 3, 1234));
        vecs.push_back(mk(0, 0, 1, 0, 999,  P, 3, 1234));
        vecs.push_back(mk(0, 0, 0, 0, 999,  P, 3, 1234));
        vecs.push_back(mk(0, 0, 0, 1, 0,    P, 3, 1234));
        vecs.push_back(mk(1, 0, 0, 0, 0,    P, 3, 1234));
        vecs.push_back(mk(0, 0, 0, 0, 0,    P, 3, 1234));
        vecs.push_back(mk(0, 1, 0, 0, 0,    P, 3, 1234));
        vecs.push_back(mk(0, 0, 0, 0, 0,    R, 3, 1234));
        vecs.push_back(mk(0, 0, 1, 0, 7,    R, 3, 1234));
        vecs.push_back(mk(0, 0, 0, 1, 7,    E, 3, 1241));
        vecs.push_back(mk(0, 0, 0, 0, 0,    A, 4, 1241));
        vecs.push_back(mk(0, 0, 0, 0, 0,    A, 4, 1241));
        vecs.push_back(mk(0, 0, 0, 0, 0,    R, 4, 1241));
        vecs.push_back(mk(1, 0, 0, 0, 0,    R, 4, 1241));
        vecs.push_back(mk(0, 0, 0, 0, 0,    R, 4, 1241));
        vecs.push_back(mk(0, 0, 0, 1, 0,    E, 4, 1241));
        vecs.push_back(mk(0, 0, 0, 0, 0,    A, 5, 1241));
        vecs.push_back(mk(0, 0, 0, 0, 0,    A, 5, 1241));
        vecs.push_back(mk(0, 0, 0, 0, 0,    R, 5, 1241));
        vecs.push_back(mk(0, 0, 0, 1, 0,    E, 5, 1241));
        vecs.push_back(mk(0, 0, 0, 0, 0,    O, 5, 1241));
        vecs.push_back(mk(0, 0, 0, 0, 0,    O, 5, 1241));
        vecs.push_back(mk(1, 0, 0, 0, 0,    O, 5, 1241));
        vecs.push_back(mk(0, 0, 0, 0, 0,    A, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,    A, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,    R, 1, 0));

        repeat (3) @(negedge clk);
        chk("reset_state", {6'd0, act_outs()}, {6'd0, exp_outs(I, 0, 0)});
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].s, vecs[i].p, vecs[i].h, vecs[i].e, vecs[i].tv);
            tick();
            chk($sformatf("vec%0d", i), {6'd0, act_outs()},
                {6'd0, exp_outs(vecs[i].st, vecs[i].rnd, vecs[i].sc)});
        end

        // Pause and hold for 1000 cycles, then resume.
        drive(0, 1, 0, 0, 12'd500); tick();
        drive(0, 0, 0, 0, 12'd500); tick();
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (timer_enable !== 1'b0 || state !== P) bad++;
        end
        chk("pause_hold", bad, 0);
        drive(0, 1, 0, 0, 12'd500); tick();
        drive(0, 0, 0, 0, 12'd500); tick();
        chk("resume", {29'd0, state}, {29'd0, R});
        chk("resume_en", {31'd0, timer_enable}, 32'd1);

        // Expire rounds 1 and 2 to reach round 3 RUN.
        for (int r = 0; r < 2; r++) begin
            drive(0, 0, 0, 1, 0); tick();
            drive(0, 0, 0, 0, 0); tick(); tick(); tick();
        end
        chk("round3_run", {26'd0, round, state}, {26'd0, 3'd3, R});

        // Asynchronous reset mid-round, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {6'd0, act_outs()}, {6'd0, exp_outs(I, 0, 0)});
        @(negedge clk);
        start_btn = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("held_start", {26'd0, round, state}, {26'd0, 3'd0, I});
        start_btn = 1'b0;
        repeat (3) tick();
        chk("held_start_rel", {29'd0, state}, {29'd0, I});

        // Saturation on the 13-bit score instance (max 8191).
        s_start = 1'b1; tick();
        s_start = 1'b0; tick();
        sat_round(12'd4095, 13'd4095, "sat_r1");
        sat_round(12'd4095, 13'd8190, "sat_r2");
        sat_round(12'd4095, 13'd8191, "sat_r3");
        sat_round(12'd100,  13'd8191, "sat_r4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Game-round controller that sequences the 12-bit countdown timer. It arms the timer, runs it, pauses it and stops it across a fixed number of rounds, and accumulates a score from the timer value remaining when the player hits. It sits between the debounced button inputs and the `countdown_timer` instance, and drives that timer's `reset` and `enable` pins.

## Interface
- `NUM_ROUNDS`, 5: rounds per game, 1..7.
- `ROUND_W`, 3: width of `round`.
- `TIMER_W`, 12: width of `timer_value`.
- `SCORE_W`, 16: width of `score`.
- `ARM_CYCLES`, 2: length of the `timer_reset` pulse per round, in cycles (≥1).
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low; low forces every register to its reset value.
- `start_btn`  in  1  level, already synchronised and debounced; rising edge = start.
- `pause_btn`  in  1  level; rising edge = pause/resume toggle.
- `hit_btn`  in  1  level; rising edge = player hit.
- `end_reached`  in  1  from the timer; level, high when the count has expired.
- `timer_value`  in  TIMER_W  from the timer; current count.
- `timer_reset`  out  1  to the timer's active-high reset.
- `timer_enable`  out  1  to the timer's enable.
- `round`  out  ROUND_W  current round, 1-based; 0 when idle.
- `score`  out  SCORE_W  accumulated score for the current game.
- `state`  out  3  state encoding, for display and debug.
- `round_done`  out  1  one-cycle pulse at the end of each round.
- `game_over`  out  1  high while in OVER.

## Operation
- Each button goes through an edge detector, so each press gives a one-cycle pulse: `start`, `pause`, `hit`.
  - The edge detector's previous-sample register resets to 1, so a button held through reset produces no pulse.
- FSM states and encodings: IDLE=0, ARM=1, RUN=2, PAUSE=3, ROUND_END=4, OVER=5. Encodings 6 and 7 return to IDLE.
- IDLE: `start` → ARM, with `round`←1 and `score`←0. `pause` and `hit` are ignored.
- ARM: `timer_reset`=1 for exactly ARM_CYCLES cycles, using an internal counter. Then → RUN. All buttons are ignored.
- RUN: `timer_enable`=1. Event priority is `hit` > `end_reached` > `pause`.
  - `hit`: `score` ← `score` + `timer_value` sampled in that same cycle, saturating at 2^SCORE_W−1. Then → ROUND_END.
  - `end_reached` without `hit`: no score change. Then → ROUND_END.
  - `pause` alone: → PAUSE.
- PAUSE: `timer_enable`=0 and the timer holds its value. `pause` → RUN. `start`, `hit` and `end_reached` are ignored.
- ROUND_END: lasts one cycle and `round_done`=1.
  - If `round`==NUM_ROUNDS → OVER.
  - Otherwise `round`←`round`+1 → ARM.
- OVER: `game_over`=1, and `round` and `score` hold their final values. `start` → ARM with `round`←1 and `score`←0.
- `start` is ignored in every state except IDLE and OVER.

## Timing
- Moore outputs, decoded from the state register:
  - `timer_enable`=1 exactly while in RUN.
  - `timer_reset`=1 exactly while in ARM.
  - `round_done` is 1 only in ROUND_END.
  - `game_over` is 1 only in OVER.
- Latency from a button rising edge sampled at edge N:
  - The pulse is registered at N.
  - The state changes at N+1.
  - The new outputs are visible after N+1.
- `score` updates on the same edge as the RUN→ROUND_END transition.
- `end_reached` is trusted only in RUN. The ARM pulse must clear it before RUN is entered, which requires ARM_CYCLES ≥ the timer's reset latency; 2 is sufficient.
- Reset values: `state`=IDLE, `round`=0, `score`=0, `timer_reset`=0, `timer_enable`=0, `round_done`=0, `game_over`=0, ARM counter=0.
- Reset asserted mid-round returns to IDLE immediately (asynchronous); the score is lost.
- `hit` and `end_reached` in the same cycle: the hit is scored, using the `timer_value` of that cycle (normally 0).

## Structure
- Shared package `game_pkg`: state encoding constants, default NUM_ROUNDS, TIMER_W, SCORE_W.
- Sub-module `edge_detect` (parameter RESET_PREV), instantiated three times, once per button.
- The FSM, ARM counter, round counter and saturating score adder live in `round_sequencer` itself.

## Test plan
- Reset, then pulse `start_btn` → `timer_reset`=1 for exactly 2 cycles, then `timer_enable`=1, `round`=1, `score`=0.
- In RUN with `timer_value`=1234, raise `hit_btn` → `score`=1234, one `round_done` pulse, `round`=2, ARM re-entered.
- Let the timer expire (`end_reached`=1) with no hit → `score` unchanged, round advances; after 5 rounds `game_over`=1 and `timer_enable`=0.
- `pause_btn` in RUN → `timer_enable`=0, and `timer_value` is stable for 1000 cycles. A second `pause_btn` → `timer_enable`=1. `hit_btn` while paused → no score change.
- `hit_btn` and `end_reached` in the same cycle with `timer_value`=7 → `score`+=7. Score preloaded near 65535 → saturates at 65535.
- Assert `reset`=0 during round 3 RUN → all outputs return to their reset values immediately. Holding `start_btn` across reset release → remains IDLE.
